// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: clock-enable sequencer for the pipelined CPU.
// The core runs on the single system clock. This block decides on which
// cycles it advances by issuing one-cycle o_cpu_ce pulses. The pulses come
// from a free-running divider (RUN), a debounced push-button (STEP), or an
// N-pulse burst (BURST). A PC breakpoint stops the pulses and parks the
// sequencer in BP_HALT.
module cpu_clk_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter int          CNT_W           = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_div_ratio,
  input  logic             i_step_btn,
  input  logic [15:0]      i_burst_len,
  input  logic             i_bp_en,
  input  logic [31:0]      i_bp_addr,
  input  logic [31:0]      i_pc,
  output logic             o_cpu_ce,
  output logic             o_busy,
  output logic             o_halted_bp,
  output logic [CNT_W-1:0] o_tick_count
);

  // Mode encoding of i_mode.
  localparam logic [1:0] M_HALT  = 2'b00;
  localparam logic [1:0] M_RUN   = 2'b01;
  localparam logic [1:0] M_STEP  = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_BURST   = 2'b10,
    S_BP_HALT = 2'b11
  } state_t;

  // ---------------------------------------------------------------------
  // Step button: synchronizer, debounce, rising-edge strobe
  // ---------------------------------------------------------------------
  logic        r_sync0;
  logic        r_sync1;
  logic [19:0] r_db_cnt;
  logic        r_deb;
  logic        r_deb_q;
  logic        w_press;

  // Bring the raw button into the clock domain and accept a new level only
  // after it has differed from the current one for DEBOUNCE_CYCLES cycles
  // in a row. Any sample matching the current level restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_db_cnt <= '0;
      r_deb    <= 1'b0;
      r_deb_q  <= 1'b0;
    end else begin
      r_sync0 <= i_step_btn;
      r_sync1 <= r_sync0;
      r_deb_q <= r_deb;
      if (r_sync1 == r_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
        r_deb    <= r_sync1;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 20'd1;
      end
    end
  end

  // The press strobe is high for exactly one cycle after the debounced
  // level rises.
  assign w_press = r_deb & ~r_deb_q;

  // ---------------------------------------------------------------------
  // Divider and breakpoint compare
  // ---------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_remaining;
  logic             r_cpu_ce;
  logic             r_busy;
  logic             r_halted_bp;
  logic [CNT_W-1:0] r_tick_count;

  logic [CNT_W-1:0] w_eff;
  logic [CNT_W-1:0] w_eff_m1;
  logic             w_active;
  logic             w_tick;
  logic             w_wrap;
  logic             w_bp_hit;

  // A divide ratio of 0 behaves like 1, so RUN never stalls.
  assign w_eff    = (i_div_ratio == '0) ? CNT_ONE : i_div_ratio;
  assign w_eff_m1 = w_eff - CNT_ONE;
  assign w_active = (r_state == S_RUN) | (r_state == S_BURST);
  // The counter is compared against the live ratio every cycle. If the ratio
  // shrinks below the current count, the counter wraps instead of running
  // up through 2^CNT_W. Only an exact match is a tick.
  assign w_tick   = w_active & (r_cnt == w_eff_m1);
  assign w_wrap   = w_active & (r_cnt >= w_eff_m1);
  assign w_bp_hit = i_bp_en & (i_pc == i_bp_addr);

  // ---------------------------------------------------------------------
  // Sequencer decode
  // ---------------------------------------------------------------------
  state_t      w_nxt_state;
  logic        w_ce;
  logic [15:0] w_rem_nxt;
  logic        w_nxt_active;

  // Next-state and pulse decision. The priority is mode exit, then
  // breakpoint, then tick.
  always_comb begin
    w_nxt_state = r_state;
    w_ce        = 1'b0;
    w_rem_nxt   = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (i_mode == M_RUN) begin
          w_nxt_state = S_RUN;
        end else if ((i_mode == M_STEP) && w_press) begin
          w_ce = 1'b1;
        end else if ((i_mode == M_BURST) && w_press && (i_burst_len != 16'd0)) begin
          w_nxt_state = S_BURST;
          w_rem_nxt   = i_burst_len;
        end
      end
      S_RUN: begin
        if (i_mode != M_RUN) begin
          w_nxt_state = S_IDLE;
        end else if (w_tick && w_bp_hit) begin
          w_nxt_state = S_BP_HALT;
        end else if (w_tick) begin
          w_ce = 1'b1;
        end
      end
      S_BURST: begin
        // Only HALT aborts a burst. STEP and RUN let it finish.
        if (i_mode == M_HALT) begin
          w_nxt_state = S_IDLE;
          w_rem_nxt   = 16'd0;
        end else if (w_tick && w_bp_hit) begin
          w_nxt_state = S_BP_HALT;
          w_rem_nxt   = 16'd0;
        end else if (w_tick) begin
          w_ce      = 1'b1;
          w_rem_nxt = r_remaining - 16'd1;
          if (r_remaining == 16'd1) begin
            w_nxt_state = S_IDLE;
          end
        end
      end
      S_BP_HALT: begin
        if (i_mode == M_HALT) begin
          w_nxt_state = S_IDLE;
        end else if (w_press) begin
          // Step over the breakpoint without checking it again.
          w_ce        = 1'b1;
          w_nxt_state = (i_mode == M_RUN) ? S_RUN : S_IDLE;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  assign w_nxt_active = (w_nxt_state == S_RUN) | (w_nxt_state == S_BURST);

  // State register with registered outputs. The divider runs only while
  // staying in RUN/BURST and restarts from 0 on every entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_remaining  <= 16'd0;
      r_cpu_ce     <= 1'b0;
      r_busy       <= 1'b0;
      r_halted_bp  <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_remaining <= w_rem_nxt;
      r_cpu_ce    <= w_ce;
      r_busy      <= w_nxt_active;
      r_halted_bp <= (w_nxt_state == S_BP_HALT);
      if (w_ce) begin
        r_tick_count <= r_tick_count + CNT_ONE;
      end
      if (w_nxt_active && w_active) begin
        r_cnt <= w_wrap ? '0 : (r_cnt + CNT_ONE);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_cpu_ce     = r_cpu_ce;
  assign o_busy       = r_busy;
  assign o_halted_bp  = r_halted_bp;
  assign o_tick_count = r_tick_count;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Testbench for cpu_clk_ctrl. It has three parts: a table of per-cycle
// vectors for RUN, a set of directed step/burst/breakpoint/reset sequences,
// and a randomized run checked against a reference model.
module tb_cpu_clk_ctrl;

  localparam int          CNT_W = 32;
  localparam int          D     = 4;
  localparam logic [19:0] DEB   = 20'd4;

  logic             clock;
  logic             reset;
  logic [1:0]       mode;
  logic [CNT_W-1:0] div_ratio;
  logic             step_btn;
  logic [15:0]      burst_len;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic             cpu_ce;
  logic             busy;
  logic             halted_bp;
  logic [CNT_W-1:0] tick_count;

  cpu_clk_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .i_mode(mode), .i_div_ratio(div_ratio),
    .i_step_btn(step_btn), .i_burst_len(burst_len), .i_bp_en(bp_en),
    .i_bp_addr(bp_addr), .i_pc(pc), .o_cpu_ce(cpu_ce), .o_busy(busy),
    .o_halted_bp(halted_bp), .o_tick_count(tick_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mode = 2'b00; div_ratio = '0; step_btn = 1'b0; burst_len = 16'd0;
    bp_en = 1'b0; bp_addr = 32'h0; pc = 32'h0;
    repeat (2) cyc();
    check("rst_ce", {31'd0, cpu_ce}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted_bp}, 32'd0);
    check("rst_tc", tick_count, 32'd0);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_BURST = 2, ST_BPH = 3;
  int          m_st;
  logic [31:0] m_cnt;
  logic [31:0] m_tc;
  logic [15:0] m_rem;
  bit          m_ce;
  bit          m_deb;
  bit          m_deb_q;
  bit          m_hist[$];

  task automatic model_reset();
    m_st = ST_IDLE; m_cnt = 0; m_tc = 0; m_rem = 0; m_ce = 0;
    m_deb = 0; m_deb_q = 0;
    m_hist.delete();
    for (int j = 0; j < D + 2; j++) m_hist.push_back(1'b0);
  endtask

  // Advance the model by one rising edge, using the inputs present now.
  task automatic model_step();
    bit press, act, tick, wrap, bp, ce, all_opp;
    logic [31:0] eff;
    int nst;
    press = m_deb && !m_deb_q;
    eff   = (div_ratio == 0) ? 32'd1 : div_ratio;
    act   = (m_st == ST_RUN) || (m_st == ST_BURST);
    tick  = act && (m_cnt == eff - 1);
    wrap  = act && (m_cnt >= eff - 1);
    bp    = bp_en && (pc == bp_addr);
    nst   = m_st;
    ce    = 0;
    case (m_st)
      ST_IDLE: begin
        if (mode == 2'd1) nst = ST_RUN;
        else if (mode == 2'd2 && press) ce = 1;
        else if (mode == 2'd3 && press && burst_len != 0) begin
          nst = ST_BURST; m_rem = burst_len;
        end
      end
      ST_RUN: begin
        if (mode != 2'd1) nst = ST_IDLE;
        else if (tick && bp) nst = ST_BPH;
        else if (tick) ce = 1;
      end
      ST_BURST: begin
        if (mode == 2'd0) begin nst = ST_IDLE; m_rem = 0; end
        else if (tick && bp) begin nst = ST_BPH; m_rem = 0; end
        else if (tick) begin
          ce = 1;
          m_rem = m_rem - 1;
          if (m_rem == 0) nst = ST_IDLE;
        end
      end
      default: begin
        if (mode == 2'd0) nst = ST_IDLE;
        else if (press) begin
          ce = 1;
          nst = (mode == 2'd1) ? ST_RUN : ST_IDLE;
        end
      end
    endcase
    if ((nst == ST_RUN || nst == ST_BURST) && act) m_cnt = wrap ? 32'd0 : m_cnt + 1;
    else m_cnt = 0;
    m_st = nst;
    m_ce = ce;
    m_tc = m_tc + {31'd0, ce};
    // The debounced level flips once the synchronized input, which is two
    // samples old, has shown the opposite level for each of the last D samples.
    m_hist.push_front(step_btn);
    void'(m_hist.pop_back());
    all_opp = 1;
    for (int j = 2; j < D + 2; j++) if (m_hist[j] == m_deb) all_opp = 0;
    m_deb_q = m_deb;
    if (all_opp) m_deb = !m_deb;
  endtask

  // ---------------------------------------------------------------------
  // Table vectors: RUN divide-by-4, then divide-by-0, then HALT
  // ---------------------------------------------------------------------
  typedef struct {
    logic [1:0]  mode;
    logic [31:0] div;
    logic        exp_ce;
    logic        exp_busy;
    logic [31:0] exp_tc;
  } vec_t;

  vec_t vt[27];

  initial begin
    int n;
    int hold;
    int ce_q[$];
    bit found;

    for (int i = 0; i <= 20; i++)
      vt[i] = '{2'd1, 32'd4, (i > 0 && i % 4 == 0), 1'b1, 32'(i / 4)};
    for (int i = 21; i <= 24; i++)
      vt[i] = '{2'd1, 32'd0, 1'b1, 1'b1, 32'(5 + i - 20)};
    vt[25] = '{2'd0, 32'd0, 1'b0, 1'b0, 32'd9};
    vt[26] = '{2'd0, 32'd0, 1'b0, 1'b0, 32'd9};

    do_reset();
    for (int i = 0; i < 27; i++) begin
      mode = vt[i].mode;
      div_ratio = vt[i].div;
      cyc();
      check($sformatf("tbl_ce[%0d]", i), {31'd0, cpu_ce}, {31'd0, vt[i].exp_ce});
      check($sformatf("tbl_busy[%0d]", i), {31'd0, busy}, {31'd0, vt[i].exp_busy});
      check($sformatf("tbl_halted[%0d]", i), {31'd0, halted_bp}, 32'd0);
      check($sformatf("tbl_tc[%0d]", i), tick_count, vt[i].exp_tc);
    end

    // Step with a bouncing button: only the stable high gives a pulse.
    do_reset();
    mode = 2'd2;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step_btn = (i % 4 < 2);
      cyc();
      n += cpu_ce;
    end
    step_btn = 1'b1;
    repeat (10) begin cyc(); n += cpu_ce; end
    step_btn = 1'b0;
    repeat (15) begin cyc(); n += cpu_ce; end
    check("step_pulses", n, 32'd1);
    check("step_tc", tick_count, 32'd1);
    check("step_busy", {31'd0, busy}, 32'd0);

    // Burst of 3 with divide 2.
    do_reset();
    mode = 2'd3; burst_len = 16'd3; div_ratio = 32'd2;
    step_btn = 1'b1;
    ce_q.delete();
    for (int i = 0; i < 60; i++) begin
      if (i == 8) step_btn = 1'b0;
      cyc();
      if (cpu_ce) ce_q.push_back(i);
    end
    check("burst_pulses", ce_q.size(), 32'd3);
    if (ce_q.size() == 3) begin
      check("burst_gap1", ce_q[1] - ce_q[0], 32'd2);
      check("burst_gap2", ce_q[2] - ce_q[1], 32'd2);
    end
    check("burst_busy_end", {31'd0, busy}, 32'd0);
    check("burst_tc", tick_count, 32'd3);

    // Burst of 3 with divide 8. A second press during the burst is ignored.
    div_ratio = 32'd8;
    step_btn = 1'b1;
    n = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      n += cpu_ce;
      found = busy;
    end
    check("burst2_started", {31'd0, found}, 32'd1);
    step_btn = 1'b0;
    repeat (8) begin cyc(); n += cpu_ce; end
    step_btn = 1'b1;
    repeat (8) begin cyc(); n += cpu_ce; end
    step_btn = 1'b0;
    repeat (40) begin cyc(); n += cpu_ce; end
    check("burst2_pulses", n, 32'd3);
    check("burst2_tc", tick_count, 32'd6);
    check("burst2_busy_end", {31'd0, busy}, 32'd0);

    // Breakpoint in RUN, then press to step past it and resume.
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h10; div_ratio = 32'd3; mode = 2'd1;
    n = 0;
    repeat (12) begin cyc(); n += cpu_ce; end
    check("bp_no_pulse", n, 32'd0);
    check("bp_halted", {31'd0, halted_bp}, 32'd1);
    check("bp_busy", {31'd0, busy}, 32'd0);
    step_btn = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      found = cpu_ce;
    end
    check("bp_step_pulse", {31'd0, found}, 32'd1);
    check("bp_step_halted", {31'd0, halted_bp}, 32'd0);
    check("bp_step_busy", {31'd0, busy}, 32'd1);
    check("bp_step_tc", tick_count, 32'd1);
    pc = 32'h14;
    step_btn = 1'b0;
    n = 0;
    repeat (12) begin cyc(); n += cpu_ce; end
    check("bp_resume_pulses", n, 32'd4);
    check("bp_resume_tc", tick_count, 32'd5);

    // Reset in the middle of a long burst.
    do_reset();
    mode = 2'd3; burst_len = 16'd100; div_ratio = 32'd2; step_btn = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 5; i++) begin
      cyc();
      if (busy) step_btn = 1'b0;
      n += cpu_ce;
    end
    check("rstmid_pulses", n, 32'd5);
    reset = 1'b1;
    #1;
    check("rstmid_ce", {31'd0, cpu_ce}, 32'd0);
    check("rstmid_tc", tick_count, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    #2;
    reset = 1'b0;
    step_btn = 1'b0;
    n = 0;
    repeat (30) begin cyc(); n += cpu_ce; end
    check("rstmid_after_pulses", n, 32'd0);
    check("rstmid_after_busy", {31'd0, busy}, 32'd0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    hold = 0;
    bp_addr = 32'h10;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) div_ratio = 32'($urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0) burst_len = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) bp_en = 1'($urandom_range(0, 1));
      pc = 32'h10 + 32'(4 * $urandom_range(0, 2));
      if (hold == 0) begin
        step_btn = ~step_btn;
        hold = $urandom_range(1, 10);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        check("rnd_rst_ce", {31'd0, cpu_ce}, 32'd0);
        check("rnd_rst_tc", tick_count, 32'd0);
        cyc();
        reset = 1'b0;
      end
      @(posedge clock);
      model_step();
      #1;
      check($sformatf("rnd_ce[%0d]", c), {31'd0, cpu_ce}, {31'd0, m_ce});
      check($sformatf("rnd_busy[%0d]", c), {31'd0, busy},
            {31'd0, (m_st == ST_RUN || m_st == ST_BURST)});
      check($sformatf("rnd_halted[%0d]", c), {31'd0, halted_bp}, {31'd0, (m_st == ST_BPH)});
      check($sformatf("rnd_tc[%0d]", c), tick_count, m_tc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
